// File: rtl/rr_arb4_sel.sv
// rtl/rr_arb4_sel.sv - four-lane round-robin arbiter producing a hold-stable 4:1 mux select
module rr_arb4_sel #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [1:0] last;
  logic [3:0] hold_cnt;

  // Returns {found, index}; lanes after 'from' win first, 'from' itself last.
  function automatic logic [2:0] scan(input logic [1:0] from, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [3:0] owner_mask;
  logic [3:0] others;
  logic [2:0] idle_pick;
  logic [2:0] hand_pick;
  logic       hit_limit;
  logic       dropped;
  logic       release_now;

  always_comb begin
    owner_mask  = 4'b0001 << sel;
    others      = req & ~owner_mask;
    idle_pick   = scan(last, req);
    // The released owner is masked so it cannot take the very next grant.
    hand_pick   = scan(sel, others);
    hit_limit   = (hold_cnt == 4'(MAX_HOLD - 1));
    dropped     = ~req[sel];
    release_now = done | dropped | hit_limit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'd0;
      gnt      <= 4'b0000;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      last     <= 2'd3;
      hold_cnt <= 4'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_pick[2]) begin
            sel      <= idle_pick[1:0];
            gnt      <= 4'b0001 << idle_pick[1:0];
            valid    <= 1'b1;
            hold_cnt <= 4'd0;
            state    <= BUSY;
          end else begin
            gnt   <= 4'b0000;
            valid <= 1'b0;
          end
        end
        BUSY: begin
          if (!release_now) begin
            if (hold_cnt != 4'hf) hold_cnt <= hold_cnt + 4'd1;
          end else begin
            last    <= sel;
            // Only a pure hold-limit release is reported as a timeout.
            timeout <= hit_limit & ~done & ~dropped;
            if (hand_pick[2]) begin
              sel      <= hand_pick[1:0];
              gnt      <= 4'b0001 << hand_pick[1:0];
              hold_cnt <= 4'd0;
            end else begin
              gnt   <= 4'b0000;
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
